// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch unit: NOP encoding, branch address field
// and PCLATH page bits, plus the PC source selection used by the top.
package instr_fetch_unit_pkg;

  localparam logic [13:0] NOP_ENC        = 14'h0000;
  localparam int          ADDR_FIELD_MSB = 10;
  localparam int          ADDR_FIELD_LSB = 0;
  localparam int          PAGE_MSB       = 4;
  localparam int          PAGE_LSB       = 3;
  localparam int          TARGET_WIDTH   = (PAGE_MSB - PAGE_LSB + 1) + (ADDR_FIELD_MSB - ADDR_FIELD_LSB + 1);

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INCR,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_sel_e;

  // RETURN wins over CALL, which wins over GOTO, which wins over increment.
  function automatic pc_sel_e pc_select(input logic ret, input logic call,
                                        input logic jump, input logic incr);
    if (ret)       return PC_RET;
    else if (call) return PC_CALL;
    else if (jump) return PC_JUMP;
    else if (incr) return PC_INCR;
    else           return PC_HOLD;
  endfunction

  function automatic logic [TARGET_WIDTH-1:0] jump_target(input logic [4:0]  pclath,
                                                          input logic [13:0] instr);
    return {pclath[PAGE_MSB:PAGE_LSB], instr[ADDR_FIELD_MSB:ADDR_FIELD_LSB]};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_return_stack.sv
// Circular hardware return stack with silent pointer wrap. Build with
// INSTR_FETCH_STACK_FLAGS_EN to add the entry-count tracker and sticky flags.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             ovf,
  output logic             unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_dec;

  assign ptr_dec = ptr - PTR_ONE;
  assign top     = mem[ptr_dec];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pop) begin
      ptr <= ptr_dec;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_ONE;
    end
  end

`ifdef INSTR_FETCH_STACK_FLAGS_EN
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W + 1)'(1);

  logic [PTR_W:0] count;

  // The count saturates; running past either end only raises the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (pop) begin
      if (count == '0) unf <= 1'b1;
      else             count <= count - COUNT_ONE;
    end else if (push) begin
      if (count == COUNT_FULL) ovf <= 1'b1;
      else                     count <= count + COUNT_ONE;
    end
  end
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction register and return stack feeding the decoder.
// Optional macro INSTR_FETCH_STACK_FLAGS_EN enables stack_ovf/stack_unf.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          PC_WIDTH    = 13,
  parameter int          STACK_DEPTH = 8,
  parameter logic [13:0] NOP_WORD    = NOP_ENC
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [13:0]         prog_data,
  input  logic                instr_rd_en,
  input  logic                instr_flush,
  input  logic                pc_incr_en,
  input  logic                pc_j_en,
  input  logic                pc_call_en,
  input  logic                pc_ret_en,
  input  logic [4:0]          pclath,
  output logic [13:0]         instr_current,
  output logic [PC_WIDTH-1:0] pc,
  output logic                stack_ovf,
  output logic                stack_unf
);

  pc_sel_e             pc_sel;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] stack_top;
  logic                push;

  assign pc_sel    = pc_select(pc_ret_en, pc_call_en, pc_j_en, pc_incr_en);
  assign target    = PC_WIDTH'(jump_target(pclath, instr_current));
  assign push      = (pc_sel == PC_CALL);
  assign prog_addr = pc;

  // pc already points at the word after the CALL, so it is pushed as-is.
  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pc_ret_en),
    .push_data (pc),
    .top       (stack_top),
    .ovf       (stack_ovf),
    .unf       (stack_unf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else begin
      case (pc_sel)
        PC_RET:  pc <= stack_top;
        PC_CALL: pc <= target;
        PC_JUMP: pc <= target;
        PC_INCR: pc <= pc + PC_WIDTH'(1);
        default: pc <= pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              instr_current <= NOP_WORD;
    else if (instr_flush) instr_current <= NOP_WORD;
    else if (instr_rd_en) instr_current <= prog_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; flag expectations follow
// INSTR_FETCH_STACK_FLAGS_EN.
module tb_instr_fetch_unit;

`ifdef INSTR_FETCH_STACK_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [12:0] prog_addr;
  logic [13:0] prog_data;
  logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_call_en, pc_ret_en;
  logic [4:0]  pclath;
  logic [13:0] instr_current;
  logic [12:0] pc;
  logic        stack_ovf, stack_unf;

  logic        force_en;
  logic [13:0] force_val;

  int vectors;
  int miscompares;

  // Program memory model: mem[n] = 14'h3000 + n (truncated to 14 bits),
  // optionally overridden to feed a specific opcode into the instruction register.
  assign prog_data = force_en ? force_val : 14'(14'h3000 + 14'(prog_addr));

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .instr_rd_en   (instr_rd_en),
    .instr_flush   (instr_flush),
    .pc_incr_en    (pc_incr_en),
    .pc_j_en       (pc_j_en),
    .pc_call_en    (pc_call_en),
    .pc_ret_en     (pc_ret_en),
    .pclath        (pclath),
    .instr_current (instr_current),
    .pc            (pc),
    .stack_ovf     (stack_ovf),
    .stack_unf     (stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clear_strobes;
    instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0;
    pc_j_en = 0; pc_call_en = 0; pc_ret_en = 0;
  endtask

  task load_instr(input logic [13:0] w);
    force_en = 1; force_val = w; instr_rd_en = 1;
    tick;
    force_en = 0; instr_rd_en = 0;
  endtask

  task do_reset;
    @(posedge clk);
    #2 rst = 1;
    #4 rst = 0;
    tick;
  endtask

  task test_reset;
    rst = 1;
    #12;
    vectors++;
    if (pc !== 13'h0000) begin miscompares++; $display("[TB] FAIL reset_pc actual=%h required=0000", pc); end
    vectors++;
    if (instr_current !== 14'h0000) begin miscompares++; $display("[TB] FAIL reset_instr actual=%h required=0000", instr_current); end
    vectors++;
    if (prog_addr !== 13'h0000) begin miscompares++; $display("[TB] FAIL reset_prog_addr actual=%h required=0000", prog_addr); end
    vectors++;
    if ({stack_ovf, stack_unf} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags actual=%b required=00", {stack_ovf, stack_unf}); end
    @(posedge clk);
    #2 rst = 0;
    tick;
  endtask

  task test_fetch;
    logic [13:0] exp_instr;
    for (int n = 0; n < 8; n++) begin
      instr_rd_en = 1; pc_incr_en = 1;
      tick;
      clear_strobes;
      exp_instr = 14'h3000 + 14'(n);
      vectors++;
      if (instr_current !== exp_instr) begin miscompares++; $display("[TB] FAIL fetch_instr[%0d] actual=%h required=%h", n, instr_current, exp_instr); end
      repeat (3) tick;
    end
    vectors++;
    if (pc !== 13'h0008) begin miscompares++; $display("[TB] FAIL fetch_pc_end actual=%h required=0008", pc); end
    vectors++;
    if (prog_addr !== 13'h0008) begin miscompares++; $display("[TB] FAIL fetch_prog_addr actual=%h required=0008", prog_addr); end
  endtask

  task test_goto;
    load_instr(14'h2923);
    pclath = 5'b11000;
    pc_j_en = 1; instr_flush = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h1923) begin miscompares++; $display("[TB] FAIL goto_pc actual=%h required=1923", pc); end
    vectors++;
    if (instr_current !== 14'h0000) begin miscompares++; $display("[TB] FAIL goto_flush actual=%h required=0000", instr_current); end
    instr_rd_en = 1; pc_incr_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (instr_current !== 14'h0923) begin miscompares++; $display("[TB] FAIL goto_fetch actual=%h required=0923", instr_current); end
    vectors++;
    if (pc !== 13'h1924) begin miscompares++; $display("[TB] FAIL goto_fetch_pc actual=%h required=1924", pc); end
  endtask

  task test_call_ret;
    do_reset;
    pclath = 5'b00000;
    load_instr(14'h2840);
    pc_j_en = 1; instr_flush = 1;
    tick;
    clear_strobes;
    load_instr(14'h2200);
    pc_call_en = 1; instr_flush = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h0200) begin miscompares++; $display("[TB] FAIL call_pc actual=%h required=0200", pc); end
    repeat (2) tick;
    pc_ret_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h0040) begin miscompares++; $display("[TB] FAIL ret_pc actual=%h required=0040", pc); end
  endtask

  task test_nested_overflow;
    logic [12:0] exp_ret [9];
    exp_ret = '{13'h080, 13'h070, 13'h060, 13'h050, 13'h040, 13'h030, 13'h020, 13'h010, 13'h080};
    do_reset;
    pclath = 5'b00000;
    for (int k = 1; k <= 9; k++) begin
      load_instr(14'h2000 | 14'(k * 16));
      pc_call_en = 1;
      tick;
      clear_strobes;
      if (k == 8) begin
        vectors++;
        if (stack_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_early actual=%b required=0", stack_ovf); end
      end
    end
    vectors++;
    if (stack_ovf !== FLAGS_ON) begin miscompares++; $display("[TB] FAIL ovf_after_9 actual=%b required=%b", stack_ovf, FLAGS_ON); end
    for (int r = 0; r < 9; r++) begin
      pc_ret_en = 1;
      tick;
      clear_strobes;
      vectors++;
      if (pc !== exp_ret[r]) begin miscompares++; $display("[TB] FAIL nested_ret[%0d] actual=%h required=%h", r, pc, exp_ret[r]); end
      if (r == 7) begin
        vectors++;
        if (stack_unf !== 1'b0) begin miscompares++; $display("[TB] FAIL unf_early actual=%b required=0", stack_unf); end
      end
    end
    vectors++;
    if (stack_unf !== FLAGS_ON) begin miscompares++; $display("[TB] FAIL unf_after_9 actual=%b required=%b", stack_unf, FLAGS_ON); end
  endtask

  task test_async_reset;
    load_instr(14'h1234);
    @(posedge clk);
    #3 rst = 1;
    #1;
    vectors++;
    if (pc !== 13'h0000) begin miscompares++; $display("[TB] FAIL async_pc actual=%h required=0000", pc); end
    vectors++;
    if (instr_current !== 14'h0000) begin miscompares++; $display("[TB] FAIL async_instr actual=%h required=0000", instr_current); end
    vectors++;
    if ({stack_ovf, stack_unf} !== 2'b00) begin miscompares++; $display("[TB] FAIL async_flags actual=%b required=00", {stack_ovf, stack_unf}); end
    #2 rst = 0;
    tick;
  endtask

  task test_wrap;
    pclath = 5'b11000;
    load_instr(14'h2FFF);
    pc_j_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h1FFF) begin miscompares++; $display("[TB] FAIL wrap_setup actual=%h required=1FFF", pc); end
    pc_incr_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h0000) begin miscompares++; $display("[TB] FAIL wrap_pc actual=%h required=0000", pc); end
  endtask

  task test_ret_call_priority;
    do_reset;
    pclath = 5'b00000;
    load_instr(14'h2300);
    pc_call_en = 1;
    tick;
    clear_strobes;
    load_instr(14'h2400);
    pc_call_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h0400) begin miscompares++; $display("[TB] FAIL prio_setup actual=%h required=0400", pc); end
    load_instr(14'h2500);
    pc_ret_en = 1; pc_call_en = 1; pc_incr_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h0300) begin miscompares++; $display("[TB] FAIL prio_pop actual=%h required=0300", pc); end
    pc_ret_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (pc !== 13'h0000) begin miscompares++; $display("[TB] FAIL prio_ret2 actual=%h required=0000", pc); end
    vectors++;
    if (stack_unf !== 1'b0) begin miscompares++; $display("[TB] FAIL prio_unf_early actual=%b required=0", stack_unf); end
    pc_ret_en = 1;
    tick;
    clear_strobes;
    vectors++;
    if (stack_unf !== FLAGS_ON) begin miscompares++; $display("[TB] FAIL prio_unf actual=%b required=%b", stack_unf, FLAGS_ON); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    force_en = 0;
    force_val = '0;
    pclath = '0;
    clear_strobes;
    test_reset;
    test_fetch;
    test_goto;
    test_call_ret;
    test_nested_overflow;
    test_async_reset;
    test_wrap;
    test_ret_call_priority;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
